// File: rtl/target_sequencer_if.sv
// Bundles the sequencer's control and data signals between the round controller and the sequencer.
// Latency: none. The interface holds only nets.
// Backpressure: none. iStart is a level input, and the outputs are either state-driven or one-cycle pulses.
// Ports:
//   iStart, iSW   : driven by the master (round control, switch bank)
//   oMemValue     : value presented to the scorer
//   oAddr, oState : sequencer position
//   oHit, oTimeout, oDone : status outputs
interface target_sequencer_if #(
  parameter int AW = 4
) ();
  logic          iStart;
  logic [7:0]    iSW;
  logic [7:0]    oMemValue;
  logic [AW-1:0] oAddr;
  logic          oHit;
  logic          oTimeout;
  logic          oDone;
  logic [1:0]    oState;

  modport master (
    output iStart, iSW,
    input  oMemValue, oAddr, oHit, oTimeout, oDone, oState
  );

  modport slave (
    input  iStart, iSW,
    output oMemValue, oAddr, oHit, oTimeout, oDone, oState
  );
endinterface

// File: rtl/target_sequencer.sv
// Steps through a fixed target table and shows each target to the match scorer until it is hit or times out.
// Latency: SHOW starts 1 cycle after iStart, and oHit/oTimeout are registered, so they pulse 1 cycle after the deciding edge.
// Backpressure: none. iStart is ignored in SHOW and GAP, and a round always runs to DONE.
// Ports:
//   iClk, iRst : clock, synchronous active-low reset
//   bus        : target_sequencer_if slave (iStart/iSW in; oMemValue/oAddr/oHit/oTimeout/oDone/oState out)
module target_sequencer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int SHOW_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 25_000_000
) (
  input  logic                iClk,
  input  logic                iRst,
  target_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0]   SHOW_LAST = 32'(SHOW_TICKS - 1);
  localparam logic [31:0]   GAP_LAST  = 32'(GAP_TICKS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   timer_q, timer_d;
  logic          hit_q, hit_d;
  logic          timeout_q, timeout_d;

  // Only the low four index bits form a table entry. Narrower addresses are zero-extended.
  logic [3:0]    rom_idx;
  logic [7:0]    rom_value;
  logic          match;

  always_comb begin
    rom_idx   = 4'(addr_q);
    rom_value = {rom_idx, ~rom_idx};
    match     = (bus.iSW == rom_value);
  end

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      timer_q   <= '0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      hit_q     <= hit_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    hit_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d  = '0;
        timer_d = '0;
        if (bus.iStart) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        // A match on the last window cycle counts as a hit, not a timeout.
        if (match) begin
          state_d = GAP;
          timer_d = '0;
          hit_d   = 1'b1;
        end else if (timer_q == SHOW_LAST) begin
          state_d   = GAP;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (addr_q == ADDR_LAST) begin
            state_d = DONE;
          end else begin
            state_d = SHOW;
            addr_d  = addr_q + AW'(1);
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DONE: begin
        timer_d = '0;
        if (bus.iStart) begin
          state_d = SHOW;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs. Outside SHOW the scorer sees ~iSW, which can never equal iSW,
  // so each hit is scored exactly once.
  always_comb begin
    bus.oMemValue = (state_q == SHOW) ? rom_value : ~bus.iSW;
    bus.oAddr     = addr_q;
    bus.oHit      = hit_q;
    bus.oTimeout  = timeout_q;
    bus.oDone     = (state_q == DONE);
    bus.oState    = state_q;
  end

endmodule
